// File: rtl/wb_stage.sv
// wb_stage: writeback stage feeding the register bank's write port.
//
// Retires one instruction per cycle from the memory stage. ALU results are
// written one registered cycle after acceptance. Loads park the stage in
// LOAD_WAIT (stalling upstream via wait_o) until mem_ack_i. The returned
// word is then byte/halfword aligned and extended. A watchdog aborts a load
// that never gets acknowledged.
//
// Handshake: valid_i is honoured only while wait_o=0. Upstream must hold its
// instruction while wait_o=1. mem_ack_i is meaningful only in LOAD_WAIT.
//
// Ports:
//   clk_i, rst_i         clock (rising edge), async active-high reset
//   valid_i              retiring instruction present this cycle
//   rd_i                 destination register
//   result_i             ALU result for non-load instructions
//   is_load_i            instruction is a load
//   funct3_i             load type: 0 LB, 1 LH, 2 LW, 4 LBU, 5 LHU
//   addr_lo_i            load byte address bits [1:0]
//   mem_ack_i            load data valid on mem_data_i
//   mem_data_i           aligned 32-bit word from data memory
//   regwrite/wrreg/wrdata registered register-bank write port
//   wait_o               stall, high exactly while in LOAD_WAIT (FSM state)
//   err_o                one-cycle pulse: bad load or load timeout
//   instret_o            retired-instruction counter (wraps)
module wb_stage #(
    parameter int TIMEOUT_W = 8
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        valid_i,
    input  logic [4:0]  rd_i,
    input  logic [31:0] result_i,
    input  logic        is_load_i,
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  addr_lo_i,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_data_i,
    output logic        regwrite,
    output logic [4:0]  wrreg,
    output logic [31:0] wrdata,
    output logic        wait_o,
    output logic        err_o,
    output logic [31:0] instret_o
);

    typedef enum logic {
        IDLE      = 1'b0,
        LOAD_WAIT = 1'b1
    } state_t;

    localparam logic [TIMEOUT_W-1:0] CNT_MAX = '1;

    state_t               state_q, state_d;
    logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
    logic [4:0]           ld_rd_q, ld_rd_d;
    logic [2:0]           ld_f3_q, ld_f3_d;
    logic [1:0]           ld_lo_q, ld_lo_d;
    logic                 regwrite_d;
    logic [4:0]           wrreg_d;
    logic [31:0]          wrdata_d;
    logic                 err_d;
    logic [31:0]          instret_d;
    logic                 load_bad;
    logic [7:0]           ld_byte;
    logic [15:0]          ld_half;
    logic [31:0]          ld_word;

    // State is directly observable as the stall.
    assign wait_o = (state_q == LOAD_WAIT);

    // Illegal funct3, or an access not aligned to its own size.
    assign load_bad = (funct3_i == 3'd3) || (funct3_i[2:1] == 2'b11) ||
                      (((funct3_i == 3'd1) || (funct3_i == 3'd5)) && addr_lo_i[0]) ||
                      ((funct3_i == 3'd2) && (addr_lo_i != 2'd0));

    // Extract and extend the returned word using the captured load type.
    always_comb begin
        ld_byte = mem_data_i[7:0];
        case (ld_lo_q)
            2'd0: ld_byte = mem_data_i[7:0];
            2'd1: ld_byte = mem_data_i[15:8];
            2'd2: ld_byte = mem_data_i[23:16];
            2'd3: ld_byte = mem_data_i[31:24];
            default: ld_byte = mem_data_i[7:0];
        endcase
        ld_half = ld_lo_q[1] ? mem_data_i[31:16] : mem_data_i[15:0];
        case (ld_f3_q)
            3'd0:    ld_word = {{24{ld_byte[7]}}, ld_byte};
            3'd4:    ld_word = {24'd0, ld_byte};
            3'd1:    ld_word = {{16{ld_half[15]}}, ld_half};
            3'd5:    ld_word = {16'd0, ld_half};
            default: ld_word = mem_data_i;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        ld_rd_d    = ld_rd_q;
        ld_f3_d    = ld_f3_q;
        ld_lo_d    = ld_lo_q;
        regwrite_d = 1'b0;
        wrreg_d    = wrreg;
        wrdata_d   = wrdata;
        err_d      = 1'b0;
        instret_d  = instret_o;

        case (state_q)
            IDLE: begin
                if (valid_i) begin
                    if (!is_load_i) begin
                        // Writes to x0 retire but leave the write port untouched.
                        if (rd_i != 5'd0) begin
                            regwrite_d = 1'b1;
                            wrreg_d    = rd_i;
                            wrdata_d   = result_i;
                        end
                        instret_d = instret_o + 32'd1;
                    end else if (load_bad) begin
                        err_d = 1'b1;
                    end else begin
                        ld_rd_d = rd_i;
                        ld_f3_d = funct3_i;
                        ld_lo_d = addr_lo_i;
                        cnt_d   = '0;
                        state_d = LOAD_WAIT;
                    end
                end
            end
            LOAD_WAIT: begin
                if (mem_ack_i) begin
                    if (ld_rd_q != 5'd0) begin
                        regwrite_d = 1'b1;
                        wrreg_d    = ld_rd_q;
                        wrdata_d   = ld_word;
                    end
                    instret_d = instret_o + 32'd1;
                    state_d   = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    // Abort on the cycle the counter would reach its maximum.
                    if (cnt_d == CNT_MAX) begin
                        err_d   = 1'b1;
                        cnt_d   = '0;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            ld_rd_q   <= 5'd0;
            ld_f3_q   <= 3'd0;
            ld_lo_q   <= 2'd0;
            regwrite  <= 1'b0;
            wrreg     <= 5'd0;
            wrdata    <= 32'd0;
            err_o     <= 1'b0;
            instret_o <= 32'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ld_rd_q   <= ld_rd_d;
            ld_f3_q   <= ld_f3_d;
            ld_lo_q   <= ld_lo_d;
            regwrite  <= regwrite_d;
            wrreg     <= wrreg_d;
            wrdata    <= wrdata_d;
            err_o     <= err_d;
            instret_o <= instret_d;
        end
    end

endmodule
